// File: rtl/mini_subsystem_pkg.sv
// mini_subsystem_pkg: shared ALU opcodes and default datapath sizes
package mini_subsystem_pkg;
  localparam int N_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 8;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR
  } alu_op_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and no fall-through
module sync_fifo
  import mini_subsystem_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  input  logic         rd_en,
  output logic [N-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [N-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic rd_ok;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  // reads on an empty FIFO are dropped so the count can never underflow
  assign rd_ok = rd_en & ~empty;
  assign count_d = count_q + CW'(wr_en) - CW'(rd_ok);
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rd_data <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/mini_subsystem_top.sv
// mini_subsystem_top: input register -> ALU/accumulator -> FIFO, with backpressure stall
module mini_subsystem_top
  import mini_subsystem_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ext_data,
  input  logic [2:0]   alu_sel,
  input  logic         fifo_rd,
  output logic [N-1:0] fifo_out,
  output logic         fifo_empty
);
  logic [N-1:0] in_q, acc_q, acc_d, alu_res;
  logic in_vld_q, acc_vld_q, acc_vld_d, fifo_full, stall, wr_en;
  alu_op_e op;
  assign op = alu_op_e'(alu_sel);
  always_comb begin
    alu_res = op == ALU_ADD ? in_q + acc_q :
              op == ALU_SUB ? in_q - acc_q :
              op == ALU_AND ? in_q & acc_q :
              op == ALU_OR  ? in_q | acc_q :
              op == ALU_XOR ? in_q ^ acc_q :
              op == ALU_NOT ? ~in_q :
              op == ALU_SHL ? in_q << 1 : in_q >> 1;
  end
  // a full FIFO is only a stall when no slot is freed this cycle
  assign stall = acc_vld_q & fifo_full & ~fifo_rd;
  assign wr_en = acc_vld_q & (~fifo_full | fifo_rd);
  assign acc_d = stall ? acc_q : alu_res;
  assign acc_vld_d = stall ? acc_vld_q : in_vld_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '0;
      in_vld_q <= 1'b0;
      acc_q <= '0;
      acc_vld_q <= 1'b0;
    end else begin
      in_q <= ext_data;
      in_vld_q <= 1'b1;
      acc_q <= acc_d;
      acc_vld_q <= acc_vld_d;
    end
  end
  sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(acc_q),
    .rd_en(fifo_rd),
    .rd_data(fifo_out),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_mini_subsystem_top.sv
// tb_mini_subsystem_top: directed scenario tasks with hand-computed expectations
module tb_mini_subsystem_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ext_data = 8'd0;
  logic [2:0] alu_sel = 3'd0;
  logic fifo_rd = 1'b0;
  logic [7:0] fifo_out;
  logic fifo_empty;
  int tests = 0;
  int fails = 0;

  mini_subsystem_top #(.N(8), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .ext_data(ext_data),
    .alu_sel(alu_sel),
    .fifo_rd(fifo_rd),
    .fifo_out(fifo_out),
    .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_data = 8'd5; alu_sel = 3'd0; fifo_rd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests++;
      if (fifo_empty !== 1'b1) begin
        fails++; $display("FAIL reset_empty cyc%0d got=%b exp=1", i, fifo_empty);
      end
      tests++;
      if (fifo_out !== 8'd0) begin
        fails++; $display("FAIL reset_out cyc%0d got=%h exp=00", i, fifo_out);
      end
    end
  endtask

  task automatic test_accumulate();
    rst = 1'b0; ext_data = 8'd5; alu_sel = 3'd0; fifo_rd = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      cycle();
      tests++;
      if (fifo_empty !== (e < 3)) begin
        fails++; $display("FAIL acc_empty edge%0d got=%b exp=%b", e, fifo_empty, e < 3);
      end
    end
  endtask

  task automatic test_drain_while_producing();
    logic [7:0] exp;
    fifo_rd = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cycle();
      exp = 8'(5 * (i + 1));
      tests++;
      if (fifo_out !== exp) begin
        fails++; $display("FAIL drain_out rd%0d got=%h exp=%h", i, fifo_out, exp);
      end
      tests++;
      if (fifo_empty !== 1'b0) begin
        fails++; $display("FAIL drain_empty rd%0d got=%b exp=0", i, fifo_empty);
      end
    end
    fifo_rd = 1'b0;
  endtask

  task automatic test_empty_read();
    fifo_rd = 1'b1; rst = 1'b1; ext_data = 8'd5; alu_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (fifo_empty !== 1'b1 || fifo_out !== 8'd0) begin
        fails++; $display("FAIL emptyrd_rst cyc%0d got empty=%b out=%h exp empty=1 out=00", i, fifo_empty, fifo_out);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      cycle();
      tests++;
      if (fifo_empty !== (e < 3) || fifo_out !== 8'd0) begin
        fails++; $display("FAIL emptyrd_rel edge%0d got empty=%b out=%h exp empty=%b out=00", e, fifo_empty, fifo_out, e < 3);
      end
    end
    cycle();
    tests++;
    if (fifo_out !== 8'd5) begin
      fails++; $display("FAIL emptyrd_first got=%h exp=05", fifo_out);
    end
    fifo_rd = 1'b0;
  endtask

  task automatic test_opcodes();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'hFF, 8'hE1, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'hE0, 8'h78};
    for (int op = 0; op < 8; op++) begin
      rst = 1'b1; fifo_rd = 1'b0; alu_sel = 3'd0;
      cycle();
      rst = 1'b0; ext_data = 8'h0F;
      cycle();
      ext_data = 8'hF0;
      cycle();
      alu_sel = 3'(op);
      cycle();
      fifo_rd = 1'b1;
      cycle();
      tests++;
      if (fifo_out !== 8'h0F) begin
        fails++; $display("FAIL op%0d_seed got=%h exp=0F", op, fifo_out);
      end
      cycle();
      tests++;
      if (fifo_out !== exp_tab[op]) begin
        fails++; $display("FAIL op%0d_result got=%h exp=%h", op, fifo_out, exp_tab[op]);
      end
      fifo_rd = 1'b0;
    end
  endtask

  task automatic test_wrap_and_reset();
    rst = 1'b1; fifo_rd = 1'b0; alu_sel = 3'd0;
    cycle();
    rst = 1'b0; ext_data = 8'hC8;
    cycle(); cycle(); cycle();
    fifo_rd = 1'b1;
    cycle();
    tests++;
    if (fifo_out !== 8'hC8) begin
      fails++; $display("FAIL wrap_first got=%h exp=C8", fifo_out);
    end
    cycle();
    tests++;
    if (fifo_out !== 8'h90) begin
      fails++; $display("FAIL wrap_second got=%h exp=90", fifo_out);
    end
    fifo_rd = 1'b0;
    cycle();
    tests++;
    if (fifo_empty !== 1'b0) begin
      fails++; $display("FAIL wrap_nonempty got=%b exp=0", fifo_empty);
    end
    rst = 1'b1;
    cycle();
    tests++;
    if (fifo_empty !== 1'b1 || fifo_out !== 8'd0) begin
      fails++; $display("FAIL midrst got empty=%b out=%h exp empty=1 out=00", fifo_empty, fifo_out);
    end
    rst = 1'b0; ext_data = 8'h03;
    for (int e = 1; e <= 3; e++) begin
      cycle();
      tests++;
      if (fifo_empty !== (e < 3)) begin
        fails++; $display("FAIL restart_empty edge%0d got=%b exp=%b", e, fifo_empty, e < 3);
      end
    end
    fifo_rd = 1'b1;
    cycle();
    tests++;
    if (fifo_out !== 8'h03) begin
      fails++; $display("FAIL restart_value got=%h exp=03", fifo_out);
    end
    fifo_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_drain_while_producing();
    test_empty_read();
    test_opcodes();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
